match_ctrl: RTL and testbench

//  Parametrised match controller: start-of-game countdown, play-clock countdown and N per-channel
//  BCD score counters in one block. Sits between input conditioning (debounced, one-pulsed goal and

---
 rtl/game_pkg.sv | 25 ++
 rtl/bcd_updown_cnt.sv | 66 ++++++
 rtl/match_ctrl.sv | 127 ++++++++++++
 tb/tb_match_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state codes, BCD constants and a constant-time integer-to-BCD helper.
package game_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRE    = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Up to four BCD digits, digit 0 in the low nibble.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r;
    int          v;
    r = '0;
    v = value;
    for (int d = 0; d < 4; d++) begin
      r[d*BCD_W +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_cnt.sv
// Multi-digit BCD counter: load, saturating increment, decrement stopping at 0; 1-cycle update.
// No backpressure: load > inc > dec, applied every cycle they are asserted.
module bcd_updown_cnt
  import game_pkg::*;
#(
  parameter int                        DIGITS  = 2,
  parameter logic [BCD_W*DIGITS-1:0]   RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_val,
  input  logic                      inc,
  input  logic                      dec,
  output logic [BCD_W*DIGITS-1:0]   cnt,
  output logic [BCD_W*DIGITS-1:0]   nxt,
  output logic                      zero,
  output logic                      one
);

  localparam int W = BCD_W * DIGITS;

  logic all_nine;
  logic c;

  assign all_nine = (cnt == {DIGITS{BCD_MAX}});
  assign zero     = (cnt == '0);
  assign one      = (cnt == W'(1));

  // c is the ripple carry (inc) or borrow (dec) between digits.
  always_comb begin
    nxt = cnt;
    c   = 1'b1;
    if (load) begin
      nxt = load_val;
    end else if (inc && !all_nine) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (c) begin
          if (cnt[d*BCD_W +: BCD_W] == BCD_MAX) begin
            nxt[d*BCD_W +: BCD_W] = '0;
          end else begin
            nxt[d*BCD_W +: BCD_W] = cnt[d*BCD_W +: BCD_W] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end else if (dec && !zero) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (c) begin
          if (cnt[d*BCD_W +: BCD_W] == 4'd0) begin
            nxt[d*BCD_W +: BCD_W] = BCD_MAX;
          end else begin
            nxt[d*BCD_W +: BCD_W] = cnt[d*BCD_W +: BCD_W] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= RST_VAL;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/match_ctrl.sv
// Match controller: pre-play countdown, play clock, NCH BCD scores; all outputs registered (1 cycle).
// No backpressure: strobes act on arrival, rst > start > tick/goal. Best-score tracking via MATCH_HISCORE_EN.
module match_ctrl
  import game_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int SD        = 2,
  parameter int TD        = 2,
  parameter int PRE_SECS  = 3,
  parameter int PLAY_SECS = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic [NCH-1:0]        goal,
  output logic [1:0]            state,
  output logic [4*TD-1:0]       time_bcd,
  output logic [4*SD*NCH-1:0]   score_bcd,
  output logic                  finish_p
`ifdef MATCH_HISCORE_EN
  ,
  output logic [4*SD-1:0]       hi_bcd
`endif
);

  localparam logic [15:0]     PRE_B16  = to_bcd(PRE_SECS);
  localparam logic [15:0]     PLAY_B16 = to_bcd(PLAY_SECS);
  localparam logic [4*TD-1:0] PRE_BCD  = PRE_B16[4*TD-1:0];
  localparam logic [4*TD-1:0] PLAY_BCD = PLAY_B16[4*TD-1:0];

  logic            in_pre;
  logic            in_play;
  logic            time_one;
  logic            t_load;
  logic            t_dec;
  logic [4*TD-1:0] t_val;
  logic            fin_entry;

  assign in_pre    = (state == ST_PRE);
  assign in_play   = (state == ST_PLAY);
  assign fin_entry = !start && in_play && tick && time_one;

  // The last PRE tick reloads the play length instead of counting down to 0.
  assign t_load = start || (in_pre && tick && time_one);
  assign t_val  = start ? PRE_BCD : PLAY_BCD;
  assign t_dec  = !start && tick && ((in_pre && !time_one) || in_play);

  bcd_updown_cnt #(
    .DIGITS  (TD),
    .RST_VAL (PLAY_BCD)
  ) u_time (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .inc      (1'b0),
    .dec      (t_dec),
    .cnt      (time_bcd),
    .nxt      (),
    .zero     (),
    .one      (time_one)
  );

`ifdef MATCH_HISCORE_EN
  logic [4*SD-1:0] score_nxt [NCH];
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_score
    bcd_updown_cnt #(
      .DIGITS  (SD),
      .RST_VAL ('0)
    ) u_score (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .load_val ('0),
      .inc      (goal[i] && in_play && !start),
      .dec      (1'b0),
      .cnt      (score_bcd[4*SD*i +: 4*SD]),
`ifdef MATCH_HISCORE_EN
      .nxt      (score_nxt[i]),
`else
      .nxt      (),
`endif
      .zero     (),
      .one      ()
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      finish_p <= 1'b0;
    end else begin
      finish_p <= 1'b0;
      if (start) begin
        state <= ST_PRE;
      end else if (tick && time_one) begin
        if (in_pre) begin
          state <= ST_PLAY;
        end else if (in_play) begin
          state    <= ST_FINISH;
          finish_p <= 1'b1;
        end
      end
    end
  end

`ifdef MATCH_HISCORE_EN
  // Compare against next-cycle scores so a goal on the final tick is included.
  logic [4*SD-1:0] best;

  always_comb begin
    best = hi_bcd;
    for (int i = 0; i < NCH; i++) begin
      if (score_nxt[i] > best) best = score_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            hi_bcd <= '0;
    else if (fin_entry) hi_bcd <= best;
  end
`endif

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized and directed bench for match_ctrl against an integer-level game model.
module tb_match_ctrl;

  localparam int NCH       = 2;
  localparam int SD        = 2;
  localparam int TD        = 2;
  localparam int PRE_SECS  = 3;
  localparam int PLAY_SECS = 30;
  localparam int SMAX      = 10**SD - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic                start = 1'b0;
  logic [NCH-1:0]      goal = '0;
  logic [1:0]          state;
  logic [4*TD-1:0]     time_bcd;
  logic [4*SD*NCH-1:0] score_bcd;
  logic                finish_p;
`ifdef MATCH_HISCORE_EN
  logic [4*SD-1:0]     hi_bcd;
`endif

  match_ctrl #(
    .NCH(NCH), .SD(SD), .TD(TD), .PRE_SECS(PRE_SECS), .PLAY_SECS(PLAY_SECS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .goal      (goal),
    .state     (state),
    .time_bcd  (time_bcd),
    .score_bcd (score_bcd),
    .finish_p  (finish_p)
`ifdef MATCH_HISCORE_EN
    ,
    .hi_bcd    (hi_bcd)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int   m_state;
  int   m_time;
  int   m_score [NCH];
  int   m_hi;
  logic m_fin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int value);
    logic [15:0] r;
    int          v;
    r = '0;
    v = value;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic t, input logic [NCH-1:0] g);
    if (r) begin
      m_state = 0; m_time = PLAY_SECS; m_fin = 1'b0; m_hi = 0;
      for (int i = 0; i < NCH; i++) m_score[i] = 0;
    end else begin
      m_fin = 1'b0;
      if (s) begin
        m_state = 1; m_time = PRE_SECS;
        for (int i = 0; i < NCH; i++) m_score[i] = 0;
      end else if (m_state == 1) begin
        if (t) begin
          if (m_time == 1) begin m_state = 2; m_time = PLAY_SECS; end
          else m_time = m_time - 1;
        end
      end else if (m_state == 2) begin
        for (int i = 0; i < NCH; i++)
          if (g[i] && m_score[i] < SMAX) m_score[i] = m_score[i] + 1;
        if (t) begin
          m_time = m_time - 1;
          if (m_time == 0) begin
            m_state = 3; m_fin = 1'b1;
            for (int i = 0; i < NCH; i++) if (m_score[i] > m_hi) m_hi = m_score[i];
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic t, input logic [NCH-1:0] g);
    logic [15:0]         tb16;
    logic [4*SD*NCH-1:0] exp_sc;
    @(negedge clk);
    rst = r; start = s; tick = t; goal = g;
    @(posedge clk);
    model_step(r, s, t, g);
    #1;
    tb16 = bcd(m_time);
    for (int i = 0; i < NCH; i++) begin
      logic [15:0] sc16;
      sc16 = bcd(m_score[i]);
      exp_sc[4*SD*i +: 4*SD] = sc16[4*SD-1:0];
    end
    check("state", 64'(state), 64'(m_state));
    check("time", 64'(time_bcd), 64'(tb16[4*TD-1:0]));
    check("score", 64'(score_bcd), 64'(exp_sc));
    check("finish_p", 64'(finish_p), 64'(m_fin));
`ifdef MATCH_HISCORE_EN
    tb16 = bcd(m_hi);
    check("hi", 64'(hi_bcd), 64'(tb16[4*SD-1:0]));
`endif
  endtask

  initial begin
    step(1, 0, 0, '0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_time", 64'(time_bcd), 64'h30);
    check("rst_score", 64'(score_bcd), 64'h0);
    check("rst_fin", 64'(finish_p), 64'd0);

    step(0, 0, 1, 2'b11);
    step(0, 1, 0, '0);
    check("pre_time", 64'(time_bcd), 64'h03);
    step(0, 0, 0, 2'b11);
    check("pre_goal", 64'(score_bcd), 64'h0);
    repeat (2) step(0, 0, 1, '0);
    check("pre_01", 64'(time_bcd), 64'h01);
    step(0, 0, 1, '0);
    check("play_state", 64'(state), 64'd2);
    check("play_time", 64'(time_bcd), 64'h30);

    repeat (10) step(0, 0, 0, 2'b11);
    check("both_10", 64'(score_bcd), 64'h1010);
    repeat (89) step(0, 0, 0, 2'b01);
    check("ch0_99", 64'(score_bcd), 64'h1099);
    step(0, 0, 0, 2'b01);
    check("ch0_sat", 64'(score_bcd), 64'h1099);

    repeat (21) step(0, 0, 1, '0);
    check("borrow_09", 64'(time_bcd), 64'h09);
    repeat (8) step(0, 0, 1, '0);
    step(0, 0, 1, 2'b10);
    check("fin_state", 64'(state), 64'd3);
    check("fin_pulse", 64'(finish_p), 64'd1);
    check("final_goal", 64'(score_bcd), 64'h1199);
    step(0, 0, 0, 2'b11);
    check("fin_pulse_off", 64'(finish_p), 64'd0);
    check("fin_hold", 64'(score_bcd), 64'h1199);

    step(0, 1, 0, '0);
    check("restart_sc", 64'(score_bcd), 64'h0);
    repeat (3) step(0, 0, 1, '0);
    step(0, 0, 0, 2'b01);
    step(0, 1, 1, 2'b11);
    check("midplay_state", 64'(state), 64'd1);
    check("midplay_sc", 64'(score_bcd), 64'h0);
    step(0, 0, 1, '0);
    step(1, 1, 1, 2'b11);
    check("rst_mid", 64'(time_bcd), 64'h30);

    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 1999) == 0,
           $urandom_range(0, 249) == 0 || (m_state == 0 && $urandom_range(0, 7) == 0),
           $urandom_range(0, 3) == 0,
           NCH'($urandom) & NCH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
